// File: rtl/banco_reg64_shift.sv
// 32 x 64-bit register file with two combinational read ports, one write port,
// and a combinational barrel shifter on read port 1 driven by Inst[25:20].
module banco_reg64_shift (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        RegWrite,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  input  logic [4:0]  WriteReg,
  input  logic [63:0] WriteData,
  input  logic [31:0] Inst,
  input  logic [1:0]  Shift,
  output logic [63:0] ReadData1,
  output logic [63:0] ReadData2,
  output logic [5:0]  ShiftN,
  output logic [63:0] ShiftOut
);

  logic [63:0] regFile_r [0:31];
  logic        unusedInst_s;

  function automatic logic [63:0] shiftData(input logic [63:0] data,
                                            input logic [5:0]  amount,
                                            input logic [1:0]  op);
    logic [63:0] result;
    case (op)
      2'b00:   result = data << amount;
      2'b01:   result = data >> amount;
      2'b10:   result = $signed(data) >>> amount;
      2'b11:   result = data;
      default: result = data;
    endcase
    return result;
  endfunction

  function automatic logic [63:0] readPort(input logic [4:0] idx,
                                           input logic       rst);
    logic [63:0] value;
    if (rst || (idx == 5'd0)) begin
      value = 64'd0;
    end else begin
      value = regFile_r[idx];
    end
    return value;
  endfunction

  // Register bank storage; x0 is never written so it stays at its reset value.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        regFile_r[i] <= 64'd0;
      end
    end else if (RegWrite && (WriteReg != 5'd0)) begin
      regFile_r[WriteReg] <= WriteData;
    end
  end

  // Read ports and shifter; no write bypass, x0 and reset force zero.
  always_comb begin
    ReadData1 = readPort(ReadReg1, Reset);
    ReadData2 = readPort(ReadReg2, Reset);
    ShiftN    = Inst[25:20];
    ShiftOut  = shiftData(ReadData1, Inst[25:20], Shift);
  end

  assign unusedInst_s = ^{Inst[31:26], Inst[19:0]};

endmodule

// File: tb/tb_banco_reg64_shift.sv
// Directed self-checking bench for banco_reg64_shift.
module tb_banco_reg64_shift;

  logic        Clk;
  logic        Reset;
  logic        RegWrite;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [4:0]  WriteReg;
  logic [63:0] WriteData;
  logic [31:0] Inst;
  logic [1:0]  Shift;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  logic [5:0]  ShiftN;
  logic [63:0] ShiftOut;

  int checkCount;
  int errorCount;

  banco_reg64_shift dut (
    .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
    .WriteData(WriteData), .Inst(Inst), .Shift(Shift),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .ShiftN(ShiftN), .ShiftOut(ShiftOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [63:0] observed,
                          input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic doWrite(input logic [4:0] idx, input logic [63:0] data);
    @(negedge Clk);
    RegWrite  = 1'b1;
    WriteReg  = idx;
    WriteData = data;
    @(posedge Clk);
    #1;
    RegWrite  = 1'b0;
  endtask

  localparam logic [63:0] X7VAL = 64'h8000000000000010;
  logic [63:0] shiftExp4 [4];
  logic [63:0] shiftExp63 [4];

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    Reset = 1'b1; RegWrite = 1'b0; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    WriteReg = 5'd0; WriteData = 64'd0; Inst = 32'd0; Shift = 2'b11;
    shiftExp4  = '{64'h0000000000000100, 64'h0800000000000001,
                   64'hF800000000000001, 64'h8000000000000010};
    shiftExp63 = '{64'h0000000000000000, 64'h0000000000000001,
                   64'hFFFFFFFFFFFFFFFF, 64'h8000000000000010};
    repeat (2) @(posedge Clk);
    #1;
    checkVal("rst_rd1", ReadData1, 64'd0);
    Reset = 1'b0;

    // Every register reads zero after reset on both ports.
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = i[4:0];
      ReadReg2 = 5'(31 - i);
      #1;
      checkVal($sformatf("rst_x%0d_p1", i), ReadData1, 64'd0);
      checkVal($sformatf("rst_x%0d_p2", 31 - i), ReadData2, 64'd0);
    end

    doWrite(5'd5, 64'h0123456789ABCDEF);
    doWrite(5'd31, 64'hFFFFFFFFFFFFFFFF);
    ReadReg1 = 5'd5; ReadReg2 = 5'd31;
    #1;
    checkVal("wr_x5", ReadData1, 64'h0123456789ABCDEF);
    checkVal("wr_x31", ReadData2, 64'hFFFFFFFFFFFFFFFF);

    doWrite(5'd0, 64'hDEAD);
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    #1;
    checkVal("x0_p1", ReadData1, 64'd0);
    checkVal("x0_p2", ReadData2, 64'd0);

    // Disabled write must not modify x5.
    @(negedge Clk);
    RegWrite = 1'b0; WriteReg = 5'd5; WriteData = 64'h1;
    @(posedge Clk);
    #1;
    ReadReg1 = 5'd5;
    #1;
    checkVal("nowr_x5", ReadData1, 64'h0123456789ABCDEF);

    // Same-cycle read/write: old value before the edge, new after.
    @(negedge Clk);
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 64'h2;
    #1;
    checkVal("rw_before", ReadData1, 64'h0123456789ABCDEF);
    @(posedge Clk);
    #1;
    RegWrite = 1'b0;
    checkVal("rw_after", ReadData1, 64'h2);
    ReadReg2 = 5'd5;
    #1;
    checkVal("dual_p1", ReadData1, 64'h2);
    checkVal("dual_p2", ReadData2, 64'h2);

    // Shifter on x7 with amount 4, other Inst bits set to prove they are ignored.
    doWrite(5'd7, X7VAL);
    ReadReg1 = 5'd7;
    Inst = 32'hFC4FFFFF;
    #1;
    checkVal("shiftn4", {58'd0, ShiftN}, 64'd4);
    for (int s = 0; s < 4; s++) begin
      Shift = s[1:0];
      #1;
      checkVal($sformatf("sh4_op%0d", s), ShiftOut, shiftExp4[s]);
    end

    Inst = 32'h03F00000;
    #1;
    checkVal("shiftn63", {58'd0, ShiftN}, 64'd63);
    for (int s = 0; s < 4; s++) begin
      Shift = s[1:0];
      #1;
      checkVal($sformatf("sh63_op%0d", s), ShiftOut, shiftExp63[s]);
    end

    Inst = 32'h00000000;
    for (int s = 0; s < 4; s++) begin
      Shift = s[1:0];
      #1;
      checkVal($sformatf("sh0_op%0d", s), ShiftOut, X7VAL);
    end

    // All-ones source distinguishes logical from arithmetic right shift.
    ReadReg1 = 5'd31;
    Inst = 32'h00400000;
    Shift = 2'b01;
    #1;
    checkVal("ones_lsr4", ShiftOut, 64'h0FFFFFFFFFFFFFFF);
    Shift = 2'b10;
    #1;
    checkVal("ones_asr4", ShiftOut, 64'hFFFFFFFFFFFFFFFF);

    // Asynchronous reset between edges clears x5 before the next edge.
    ReadReg1 = 5'd5;
    Shift = 2'b11;
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    checkVal("async_rd1", ReadData1, 64'd0);
    checkVal("async_shout", ShiftOut, 64'd0);

    // Write attempted while reset is held is ignored.
    @(negedge Clk);
    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 64'hAAAA;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    RegWrite = 1'b0;
    ReadReg1 = 5'd9; ReadReg2 = 5'd5;
    #1;
    checkVal("rstwr_x9", ReadData1, 64'd0);
    checkVal("rst_x5", ReadData2, 64'd0);

    doWrite(5'd9, 64'h55);
    #1;
    checkVal("postrst_x9", ReadData1, 64'h55);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
